// File: rtl/keypad_pkg.sv
// Shared types and sizes for the keypad scanner: FSM states, scan-result kinds
// and matrix geometry.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 4;
   localparam int KEY_W    = 4;

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      HELD,
      DEB_REL
   } key_state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } scan_kind_t;

endpackage

// File: rtl/keypad_col_strobe.sv
// Column strobe: dwell divider plus one-hot-low column rotation, with a sample
// strobe at the last dwell cycle and a scan-complete strobe on column 3.
module keypad_col_strobe
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic [NUM_COLS-1:0] col_out,
   output logic [1:0]          col_idx,
   output logic                sample_en,
   output logic                scan_done
);

   localparam int              DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

   logic [DIV_W-1:0] div_q;

   assign sample_en = (div_q == DIV_LAST);
   assign scan_done = sample_en && (col_idx == 2'd3);

   // col_out is kept as its own register so the pad drive never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         col_idx <= 2'd0;
         col_out <= 4'b1110;
      end else if (sample_en) begin
         div_q   <= '0;
         col_idx <= col_idx + 2'd1;
         col_out <= {col_out[NUM_COLS-2:0], col_out[NUM_COLS-1]};
      end else begin
         div_q   <= div_q + DIV_W'(1);
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: strobes columns, synchronises rows, classifies each full
// scan and debounces presses/releases into a single key_pressed pulse.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [NUM_ROWS-1:0] row_in,
   output logic [NUM_COLS-1:0] col_out,
   output logic                key_pressed,
   output logic [KEY_W-1:0]    key_value,
   output logic                key_held
);

   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE_SCANS);

   logic [1:0]          col_idx;
   logic                sample_en;
   logic                scan_done;
   logic [NUM_ROWS-1:0] row_s1, row_s2;

   keypad_col_strobe #(.SCAN_DIV(SCAN_DIV)) u_strobe (
      .clk       (clk),
      .rst_n     (rst_n),
      .col_out   (col_out),
      .col_idx   (col_idx),
      .sample_en (sample_en),
      .scan_done (scan_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_s1 <= 4'hF;
         row_s2 <= 4'hF;
      end else begin
         row_s1 <= row_in;
         row_s2 <= row_s1;
      end
   end

   // Per-column hit count and lowest low row; the accumulator saturates at 2
   // because anything beyond one hit is MULTI regardless of how many.
   logic [2:0]       col_hits;
   logic [1:0]       col_row;
   logic [1:0]       acc_n_q, acc_n_in, acc_n_next;
   logic [KEY_W-1:0] acc_code_q, code_next;
   logic [2:0]       sum;

   always_comb begin
      col_hits = '0;
      col_row  = '0;
      for (int r = NUM_ROWS - 1; r >= 0; r--) begin
         if (!row_s2[r]) begin
            col_hits = col_hits + 3'd1;
            col_row  = 2'(r);
         end
      end
      acc_n_in   = (col_idx == 2'd0) ? 2'd0 : acc_n_q;
      sum        = {1'b0, acc_n_in} + col_hits;
      acc_n_next = (sum >= 3'd2) ? 2'd2 : sum[1:0];
      code_next  = (acc_n_in == 2'd0) ? {col_row, col_idx} : acc_code_q;
   end

   logic             res_valid_q;
   scan_kind_t       res_kind_q;
   logic [KEY_W-1:0] res_code_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_n_q     <= '0;
         acc_code_q  <= '0;
         res_valid_q <= 1'b0;
         res_kind_q  <= NONE;
         res_code_q  <= '0;
      end else begin
         res_valid_q <= 1'b0;
         if (sample_en) begin
            acc_n_q    <= acc_n_next;
            acc_code_q <= code_next;
         end
         if (scan_done) begin
            res_valid_q <= 1'b1;
            res_code_q  <= code_next;
            case (acc_n_next)
               2'd0:    res_kind_q <= NONE;
               2'd1:    res_kind_q <= SINGLE;
               default: res_kind_q <= MULTI;
            endcase
         end
      end
   end

   key_state_t       state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [KEY_W-1:0] cand_q, cand_d;
   logic [KEY_W-1:0] value_d;
   logic             pulse_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      value_d = key_value;
      pulse_d = 1'b0;
      if (res_valid_q) begin
         case (state_q)
            IDLE: begin
               if (res_kind_q == SINGLE) begin
                  state_d = DEB_PRESS;
                  cand_d  = res_code_q;
                  cnt_d   = 4'd1;
               end
            end
            DEB_PRESS: begin
               if (res_kind_q == SINGLE && res_code_q == cand_q) begin
                  if (cnt_q + 4'd1 == DEB_LAST) begin
                     state_d = HELD;
                     cnt_d   = 4'd0;
                     pulse_d = 1'b1;
                     value_d = cand_q;
                  end else begin
                     cnt_d   = cnt_q + 4'd1;
                  end
               end else if (res_kind_q == SINGLE) begin
                  cand_d = res_code_q;
                  cnt_d  = 4'd1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = 4'd0;
               end
            end
            HELD: begin
               if (res_kind_q == NONE) begin
                  state_d = DEB_REL;
                  cnt_d   = 4'd1;
               end
            end
            DEB_REL: begin
               if (res_kind_q == NONE) begin
                  if (cnt_q + 4'd1 == DEB_LAST) begin
                     state_d = IDLE;
                     cnt_d   = 4'd0;
                  end else begin
                     cnt_d   = cnt_q + 4'd1;
                  end
               end else begin
                  state_d = HELD;
                  cnt_d   = 4'd0;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         cand_q      <= '0;
         key_value   <= '0;
         key_pressed <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cand_q      <= cand_d;
         key_value   <= value_d;
         key_pressed <= pulse_d;
      end
   end

   assign key_held = (state_q == HELD) || (state_q == DEB_REL);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Upstream input stage of the keypad lock datapath.
- Strobes a 4x4 matrix keypad, synchronises and debounces the row returns, and encodes a single pressed key to a 4-bit code.
- Emits exactly one key_pressed pulse per physical press. The downstream password buffer consumes key_pressed/key_value directly.

Parameters:
- SCAN_DIV, 50000: clk cycles each column is driven (dwell). Legal range is 4 or more.
- DEBOUNCE_SCANS, 4: consecutive identical full-matrix scans required to accept a press or a release. Legal range is 2 to 15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- row_in  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
- col_out  output  4  column drive, active-low, exactly one bit low at any time
- key_pressed  output  1  one-cycle pulse when a press is accepted
- key_value  output  4  code of the last accepted key. Valid whenever key_pressed=1 and held until the next press.
- key_held  output  1  high while an accepted key is still considered down

Behaviour:
- Reset values:
  - col_out=4'b1110; key_pressed=0; key_value=0; key_held=0.
  - Synchroniser flops=4'hF; FSM=IDLE; all counters=0.
  - Reset mid-operation aborts any debounce, with no pulse emitted.
- Synchroniser: 2-flop synchroniser on row_in. All logic uses the synchronised rows only.
- Column sequencing:
  - Divider counts 0..SCAN_DIV-1.
  - On wrap, the active column advances c=0,1,2,3,0: col_out=1110,1101,1011,0111.
  - Full scan period is 4*SCAN_DIV cycles.
- Sampling: synchronised rows are sampled only at divider count SCAN_DIV-1. The earlier cycles are settle time plus synchroniser latency.
- Key code: row r low while column c is driven gives key_value = 4*r + c (range 0..15).
- Scan result, registered at the end of column 3 sampling:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one row/column hit in the whole scan.
  - MULTI: two or more hits. MULTI is treated as not-SINGLE everywhere and never reported.
- FSM (evaluated once per scan result; a 4-bit debounce counter cnt):
  - IDLE: SINGLE(k) -> DEB_PRESS, cand=k, cnt=1. Otherwise stay.
  - DEB_PRESS:
    - SINGLE(cand) -> cnt+1. When cnt reaches DEBOUNCE_SCANS: pulse key_pressed for one clk, load key_value=cand, go to HELD.
    - SINGLE(other) -> restart with cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD: key_held=1. NONE -> DEB_REL, cnt=1. SINGLE of any code or MULTI -> stay. No auto-repeat; a second key while held is ignored.
  - DEB_REL: key_held stays 1.
    - NONE -> cnt+1. When cnt reaches DEBOUNCE_SCANS -> IDLE and key_held=0.
    - Any hit -> back to HELD, with no new pulse.
- Latency: key_pressed is asserted the cycle after the scan-result register captures the DEBOUNCE_SCANS-th consecutive matching SINGLE.
- Minimum press-to-pulse time: DEBOUNCE_SCANS full scans, plus up to one scan of alignment.
- key_pressed is never high for two consecutive cycles and never fires twice without passing through IDLE.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state enum (IDLE, DEB_PRESS, HELD, DEB_REL);
  - NUM_ROWS=4, NUM_COLS=4, KEY_W=4;
  - scan-result kind enum (NONE, SINGLE, MULTI).
- One sub-module: keypad_col_strobe. It contains the divider plus the column one-hot-low sequencer and outputs col_out, col_idx[1:0], sample_en and scan_done.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, scan period 16 clk):
- Reset: hold rst_n low, then release -> col_out=1110; all outputs 0; col_out steps 1110->1101->1011->0111 every 4 clk.
- Clean press: row 2 low only while col 1 is driven, for 5 scans -> exactly one key_pressed pulse with key_value=9, 3 scans after press start; key_held=1.
- Release: release the row -> key_held drops after 3 NONE scans; a re-press of key 9 then yields a second pulse.
- Bounce: key 5 toggled present/absent on alternate scans for 8 scans -> no key_pressed; FSM returns to IDLE.
- Ghosting: keys 0 and 15 held together for 6 scans -> no pulse. Then release 15 only -> pulse with key_value=0 after 3 scans.
- Reset mid-debounce: assert rst_n during DEB_PRESS at cnt=2 -> no pulse; outputs return to reset values; a fresh press needs 3 full scans.
